// File: rtl/decoder_pkg.sv
// Shared types and the binary-to-one-hot decode used by the skid-buffered decoder.
package decoder_pkg;

    localparam int unsigned BIN_W = 4;
    localparam int unsigned OH_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } dec_state_t;

    // A low enable yields an all-zero word rather than a one-hot code.
    function automatic logic [OH_W-1:0] onehot_decode(input logic [BIN_W-1:0] bin,
                                                      input logic             en);
        logic [OH_W-1:0] word;
        word = '0;
        if (en) begin
            word[bin] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/decoder_using_skid.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer so that
// in_ready comes straight from a flop while sustaining one word per cycle.
module decoder_using_skid #(
    parameter int unsigned BIN_W = decoder_pkg::BIN_W,
    parameter int unsigned OH_W  = decoder_pkg::OH_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BIN_W-1:0] binary_in,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OH_W-1:0]  decoder_out,
    output logic             out_valid,
    input  logic             out_ready
);
    import decoder_pkg::*;

    if (OH_W != 2 ** BIN_W) begin : g_width_check
        $error("decoder_using_skid: OH_W must equal 2**BIN_W");
    end

    dec_state_t      state_q, state_d;
    logic [OH_W-1:0] main_q, main_d;
    logic [OH_W-1:0] skid_q, skid_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [OH_W-1:0] word_c;
    logic            in_xfer_c;
    logic            out_xfer_c;

    assign word_c     = onehot_decode(binary_in, enable);
    assign in_xfer_c  = in_valid && in_ready_q;
    assign out_xfer_c = out_valid_q && out_ready;

    // Next state and storage update; flags are precomputed from the next state
    // so they leave the block directly from flops.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer_c) begin
                    state_d = ONE;
                    main_d  = word_c;
                end
            end
            ONE: begin
                if (in_xfer_c && !out_xfer_c) begin
                    state_d = TWO;
                    skid_d  = word_c;
                end else if (in_xfer_c && out_xfer_c) begin
                    main_d = word_c;
                end else if (out_xfer_c) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer_c) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign decoder_out = main_q;

endmodule

// File: tb/tb_decoder_using_skid.sv
// Self-checking bench for decoder_using_skid: vector table, backpressure and
// reset corner sequences, and a random-handshake run against an in-order scoreboard.
module tb_decoder_using_skid;
    import decoder_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [BIN_W-1:0] binary_in;
    logic            enable;
    logic            in_valid;
    logic            in_ready;
    logic [OH_W-1:0] decoder_out;
    logic            out_valid;
    logic            out_ready;

    decoder_using_skid #(.BIN_W(BIN_W), .OH_W(OH_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .binary_in   (binary_in),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .decoder_out (decoder_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_pop = 0;
    logic [OH_W-1:0] sb[$];

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             en;
        logic [OH_W-1:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1, so at negedge both inputs and registered
    // outputs are stable and predict exactly what the next edge transfers.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_word", 32'(decoder_out), 32'hdead_beef);
                end else begin
                    chk("sb_word", 32'(decoder_out), 32'(sb.pop_front()));
                end
                n_pop++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(onehot_decode(binary_in, enable));
                n_push++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        int   accepted;
        int   cycles;

        for (int i = 0; i < 16; i++) begin
            vecs[i].bin = BIN_W'(i);
            vecs[i].en  = 1'b1;
            vecs[i].exp = OH_W'(1) << i;
        end
        vecs[16] = '{bin: 4'd9, en: 1'b0, exp: 16'h0000};
        vecs[17] = '{bin: 4'd9, en: 1'b1, exp: 16'h0200};

        // Reset held with a word on offer: nothing may be captured.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        binary_in = 4'd5;
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_decoder_out", 32'(decoder_out), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        chk("rst_nothing_captured", 32'(out_valid), 32'd0);

        // Vector table: sweep 0..15 back-to-back, then enable low / high on index 9.
        for (int k = 0; k < 18; k++) begin
            in_valid  = 1'b1;
            binary_in = vecs[k].bin;
            enable    = vecs[k].en;
            tick();
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_decoder_out", k), 32'(decoder_out), 32'(vecs[k].exp));
            chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: two words fit, the third waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        enable    = 1'b1;
        binary_in = 4'd3;
        tick();
        chk("bp_first_in_ready", 32'(in_ready), 32'd1);
        chk("bp_first_out", 32'(decoder_out), 32'h0008);
        binary_in = 4'd7;
        tick();
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_out", 32'(decoder_out), 32'h0008);
        binary_in = 4'd11;
        repeat (2) begin
            tick();
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_out", 32'(decoder_out), 32'h0008);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out", 32'(decoder_out), 32'h0080);
        tick();
        in_valid = 1'b0;
        chk("bp_third_out", 32'(decoder_out), 32'h0800);
        tick();
        chk("bp_empty_out_valid", 32'(out_valid), 32'd0);

        // Random handshake with scoreboard checking at the monitor.
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 99) < 80);
            out_ready = ($urandom_range(0, 99) < 75);
            binary_in = BIN_W'($urandom_range(0, 15));
            enable    = ($urandom_range(0, 9) != 0);
            if (in_valid && in_ready) accepted++;
            tick();
            cycles++;
        end
        chk("rand_accepted", 32'(accepted), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (out_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        chk("rand_drained", 32'(out_valid), 32'd0);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_push_pop", 32'(n_pop), 32'(n_push));

        // Reset mid-operation while holding two words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        enable    = 1'b1;
        binary_in = 4'd2;
        tick();
        binary_in = 4'd4;
        tick();
        chk("mid_two_in_ready", 32'(in_ready), 32'd0);
        chk("mid_two_out", 32'(decoder_out), 32'h0004);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_decoder_out", 32'(decoder_out), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        binary_in = 4'd6;
        tick();
        in_valid = 1'b0;
        chk("mid_first_out_valid", 32'(out_valid), 32'd1);
        chk("mid_first_out", 32'(decoder_out), 32'h0040);
        out_ready = 1'b1;
        tick();
        chk("mid_final_empty", 32'(out_valid), 32'd0);
        chk("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
